seq_bit_serializer: RTL and testbench



---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_bit_serializer_if.sv | 35 +++
 rtl/ser_hold_slot.sv | 37 +++
 rtl/seq_bit_serializer.sv | 106 ++++++++++
 tb/tb_seq_bit_serializer.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the serializer
// and the sequence-detector stage it feeds.
package seq_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   localparam int   SER_WIDTH    = 8;
   localparam logic SER_IDLE_BIT = 1'b0;

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Parallel-in handshake plus serial-out bundle
// of the bit serializer.
interface seq_bit_serializer_if #(
   parameter int WIDTH = seq_pkg::SER_WIDTH
);

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             ser_bit;
   logic             ser_valid;
   logic             word_start;
   logic             busy;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  ser_bit,
      input  ser_valid,
      input  word_start,
      input  busy
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output ser_bit,
      output ser_valid,
      output word_start,
      output busy
   );

endinterface

// File: rtl/ser_hold_slot.sv
// One-entry holding register that parks the next
// word while the shifter is still busy.
module ser_hold_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             load_slot,
   output logic [WIDTH-1:0] hold,
   output logic             hold_full,
   output logic             in_ready,
   output logic             accept
);

   // ready is withheld during reset so a word
   // presented alongside reset is never taken
   assign in_ready = !hold_full & !reset;
   assign accept   = in_valid & in_ready;

   // slot fill/drain; an accept during a load
   // can only happen with the slot empty, so it
   // bypasses straight to the shifter
   always_ff @(posedge clk) begin
      if (reset) begin
         hold      <= '0;
         hold_full <= 1'b0;
      end else if (load_slot) begin
         hold_full <= 1'b0;
      end else if (accept) begin
         hold      <= in_data;
         hold_full <= 1'b1;
      end
   end

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence
// detector; streams words with no gap bits.
module seq_bit_serializer
   import seq_pkg::*;
#(
   parameter int   WIDTH     = SER_WIDTH,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = SER_IDLE_BIT
) (
   input  logic                clk,
   input  logic                reset,
   seq_bit_serializer_if.slave bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   ser_state_t       state;
   ser_state_t       state_nxt;
   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] sh_shifted;
   logic [WIDTH-1:0] hold;
   logic [CW-1:0]    cnt;
   logic             hold_full;
   logic             in_ready;
   logic             accept;
   logic             load_slot;
   logic             first_out;

   // a new word may enter sh when idle or on the
   // last bit of the current word
   assign load_slot = (state == IDLE)
                    | ((state == SHIFT) & (cnt == LAST));

   assign first_out  = MSB_FIRST ? sh[WIDTH-1] : sh[0];
   assign sh_shifted = MSB_FIRST
                     ? {sh[WIDTH-2:0], 1'b0}
                     : {1'b0, sh[WIDTH-1:1]};

   ser_hold_slot #(
      .WIDTH (WIDTH)
   ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .in_data   (bus.in_data),
      .in_valid  (bus.in_valid),
      .load_slot (load_slot),
      .hold      (hold),
      .hold_full (hold_full),
      .in_ready  (in_ready),
      .accept    (accept)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next state: keep shifting while any word is
   // available at a load point
   always_comb begin
      state_nxt = state;
      if (load_slot) begin
         if (hold_full | accept) state_nxt = SHIFT;
         else                    state_nxt = IDLE;
      end
   end

   // shifter and bit counter; held word takes
   // priority over the bypass path
   always_ff @(posedge clk) begin
      if (reset) begin
         sh  <= '0;
         cnt <= '0;
      end else if (load_slot) begin
         cnt <= '0;
         if (hold_full)   sh <= hold;
         else if (accept) sh <= bus.in_data;
      end else begin
         sh  <= sh_shifted;
         cnt <= cnt + CW'(1);
      end
   end

   // serial outputs decoded from state
   always_comb begin
      bus.ser_valid  = 1'b0;
      bus.ser_bit    = IDLE_BIT;
      bus.word_start = 1'b0;
      unique case (state)
         IDLE: begin
            bus.ser_valid = 1'b0;
         end
         SHIFT: begin
            bus.ser_valid  = 1'b1;
            bus.ser_bit    = first_out;
            bus.word_start = (cnt == '0);
         end
      endcase
   end

   assign bus.in_ready = in_ready;
   assign bus.busy     = (state == SHIFT) | hold_full;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer with an
// MSB-first and an LSB-first instance.
module tb_seq_bit_serializer;
   import seq_pkg::*;

   localparam int W = SER_WIDTH;

   typedef struct packed {
      logic b;
      logic s;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t q_msb[$];
   exp_t q_lsb[$];

   always #5 clk = ~clk;

   seq_bit_serializer_if #(.WIDTH(W)) bm ();
   seq_bit_serializer_if #(.WIDTH(W)) bl ();

   seq_bit_serializer #(
      .WIDTH     (W),
      .MSB_FIRST (1'b1),
      .IDLE_BIT  (SER_IDLE_BIT)
   ) u_msb (
      .clk   (clk),
      .reset (reset),
      .bus   (bm)
   );

   seq_bit_serializer #(
      .WIDTH     (W),
      .MSB_FIRST (1'b0),
      .IDLE_BIT  (SER_IDLE_BIT)
   ) u_lsb (
      .clk   (clk),
      .reset (reset),
      .bus   (bl)
   );

   // scoreboard for the MSB-first instance
   always @(negedge clk) begin
      exp_t e;
      n_vec++;
      if (bm.ser_valid === 1'b1) begin
         if (q_msb.size() == 0) begin
            n_err++;
            $display("FAIL msb_extra_bit got=%0b required=no bit", bm.ser_bit);
         end else begin
            e = q_msb.pop_front();
            if (bm.ser_bit !== e.b || bm.word_start !== e.s) begin
               n_err++;
               $display("FAIL msb_bit got=%0b/%0b required=%0b/%0b",
                        bm.ser_bit, bm.word_start, e.b, e.s);
            end
         end
      end else if (bm.ser_valid !== 1'b0 || bm.ser_bit !== SER_IDLE_BIT
                   || bm.word_start !== 1'b0) begin
         n_err++;
         $display("FAIL msb_idle got=%0b/%0b/%0b required=0/%0b/0",
                  bm.ser_valid, bm.ser_bit, bm.word_start, SER_IDLE_BIT);
      end
      if (reset) q_msb.delete();
      else if (bm.in_valid && bm.in_ready)
         for (int i = W - 1; i >= 0; i--)
            q_msb.push_back('{b: bm.in_data[i], s: (i == W - 1)});
   end

   // scoreboard for the LSB-first instance
   always @(negedge clk) begin
      exp_t e;
      n_vec++;
      if (bl.ser_valid === 1'b1) begin
         if (q_lsb.size() == 0) begin
            n_err++;
            $display("FAIL lsb_extra_bit got=%0b required=no bit", bl.ser_bit);
         end else begin
            e = q_lsb.pop_front();
            if (bl.ser_bit !== e.b || bl.word_start !== e.s) begin
               n_err++;
               $display("FAIL lsb_bit got=%0b/%0b required=%0b/%0b",
                        bl.ser_bit, bl.word_start, e.b, e.s);
            end
         end
      end else if (bl.ser_valid !== 1'b0 || bl.ser_bit !== SER_IDLE_BIT
                   || bl.word_start !== 1'b0) begin
         n_err++;
         $display("FAIL lsb_idle got=%0b/%0b/%0b required=0/%0b/0",
                  bl.ser_valid, bl.ser_bit, bl.word_start, SER_IDLE_BIT);
      end
      if (reset) q_lsb.delete();
      else if (bl.in_valid && bl.in_ready)
         for (int i = 0; i < W; i++)
            q_lsb.push_back('{b: bl.in_data[i], s: (i == 0)});
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // present words in order, holding each until taken
   task automatic stream(input bit lsb, input logic [W-1:0] ws [4],
                         input int n, output int stalls);
      int k = 0;
      int guard = 0;
      logic rdy;
      stalls = 0;
      @(posedge clk);
      #1;
      while (k < n) begin
         if (lsb) begin bl.in_valid = 1'b1; bl.in_data = ws[k]; end
         else     begin bm.in_valid = 1'b1; bm.in_data = ws[k]; end
         @(negedge clk);
         rdy = lsb ? bl.in_ready : bm.in_ready;
         if (rdy) k++;
         else     stalls++;
         @(posedge clk);
         #1;
         guard++;
         if (guard > 100) begin
            n_vec++;
            n_err++;
            $display("FAIL stream_timeout accepted=%0d required=%0d", k, n);
            break;
         end
      end
      bm.in_valid = 1'b0;
      bl.in_valid = 1'b0;
   endtask

   // record one contiguous run of valid bits
   task automatic observe(input bit lsb, output int run,
                          output logic [63:0] bits,
                          output logic [63:0] starts,
                          output int rdy_low, output logic busy_end,
                          output logic bit_end);
      int t = 0;
      run = 0;
      bits = '0;
      starts = '0;
      rdy_low = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(lsb ? bl.ser_valid : bm.ser_valid) && t < 50);
      while ((lsb ? bl.ser_valid : bm.ser_valid) && run < 64) begin
         bits = {bits[62:0], (lsb ? bl.ser_bit : bm.ser_bit)};
         starts[run] = lsb ? bl.word_start : bm.word_start;
         if (!(lsb ? bl.in_ready : bm.in_ready)) rdy_low++;
         run++;
         @(negedge clk);
      end
      busy_end = lsb ? bl.busy : bm.busy;
      bit_end  = lsb ? bl.ser_bit : bm.ser_bit;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (bm.in_ready !== 1'b0 || bl.in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ready got=%0b/%0b required=0/0", bm.in_ready, bl.in_ready);
      end
      n_vec++;
      if (bm.busy !== 1'b0 || bm.ser_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_busy_valid got=%0b/%0b required=0/0", bm.busy, bm.ser_valid);
      end
      n_vec++;
      if (bm.ser_bit !== SER_IDLE_BIT || bm.word_start !== 1'b0) begin
         n_err++;
         $display("FAIL reset_bit_start got=%0b/%0b required=0/0", bm.ser_bit, bm.word_start);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bm.in_ready !== 1'b1 || bl.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL release_ready got=%0b/%0b required=1/1", bm.in_ready, bl.in_ready);
      end
   endtask

   task automatic test_single;
      logic [W-1:0] ws [4];
      int st, run, rl;
      logic [63:0] bits, starts;
      logic be, bt;
      ws = '{8'hA5, 8'h00, 8'h00, 8'h00};
      fork
         stream(1'b0, ws, 1, st);
         observe(1'b0, run, bits, starts, rl, be, bt);
      join
      n_vec++;
      if (run != 8 || bits[7:0] !== 8'hA5) begin
         n_err++;
         $display("FAIL single_a5 got=%0d bits %h required=8 bits a5", run, bits[7:0]);
      end
      n_vec++;
      if (starts !== 64'h1) begin
         n_err++;
         $display("FAIL single_start got=%h required=1", starts);
      end
      n_vec++;
      if (be !== 1'b0 || bt !== SER_IDLE_BIT || rl != 0) begin
         n_err++;
         $display("FAIL single_after got=%0b/%0b/%0d required=0/0/0", be, bt, rl);
      end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] ws [4];
      int st, run, rl;
      logic [63:0] bits, starts;
      logic be, bt;
      ws = '{8'h12, 8'h34, 8'h00, 8'h00};
      fork
         stream(1'b0, ws, 2, st);
         observe(1'b0, run, bits, starts, rl, be, bt);
      join
      n_vec++;
      if (run != 16 || bits[15:0] !== 16'h1234) begin
         n_err++;
         $display("FAIL b2b_bits got=%0d bits %h required=16 bits 1234", run, bits[15:0]);
      end
      n_vec++;
      if (starts !== 64'h101) begin
         n_err++;
         $display("FAIL b2b_start got=%h required=101", starts);
      end
      n_vec++;
      if (rl != 7) begin
         n_err++;
         $display("FAIL b2b_ready_low got=%0d required=7", rl);
      end
   endtask

   task automatic test_hold_stall;
      logic [W-1:0] ws [4];
      int st, run, rl;
      logic [63:0] bits, starts;
      logic be, bt;
      ws = '{8'hC3, 8'h5A, 8'h96, 8'h00};
      fork
         stream(1'b0, ws, 3, st);
         observe(1'b0, run, bits, starts, rl, be, bt);
      join
      n_vec++;
      if (run != 24 || bits[23:0] !== 24'hC35A96) begin
         n_err++;
         $display("FAIL stall_bits got=%0d bits %h required=24 bits c35a96", run, bits[23:0]);
      end
      n_vec++;
      if (st != 7) begin
         n_err++;
         $display("FAIL stall_wait got=%0d required=7", st);
      end
      n_vec++;
      if (starts !== 64'h10101 || be !== 1'b0) begin
         n_err++;
         $display("FAIL stall_start got=%h busy %0b required=10101 busy 0", starts, be);
      end
   endtask

   task automatic test_reset_mid_word;
      logic [W-1:0] ws [4];
      int st;
      int seen = 0;
      ws = '{8'hFF, 8'h0F, 8'h00, 8'h00};
      stream(1'b0, ws, 2, st);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (bm.ser_valid !== 1'b0 || bm.ser_bit !== 1'b0 || bm.busy !== 1'b0) begin
         n_err++;
         $display("FAIL abort_outputs got=%0b/%0b/%0b required=0/0/0",
                  bm.ser_valid, bm.ser_bit, bm.busy);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bm.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL abort_ready got=%0b required=1", bm.in_ready);
      end
      repeat (12) begin
         @(negedge clk);
         if (bm.ser_valid) seen++;
      end
      n_vec++;
      if (seen != 0 || q_msb.size() != 0) begin
         n_err++;
         $display("FAIL abort_held_word got=%0d bits, %0d queued required=0,0",
                  seen, q_msb.size());
      end
   endtask

   task automatic test_lsb_first;
      logic [W-1:0] ws [4];
      int st, run, rl;
      logic [63:0] bits, starts;
      logic be, bt;
      ws = '{8'h01, 8'h00, 8'h00, 8'h00};
      fork
         stream(1'b1, ws, 1, st);
         observe(1'b1, run, bits, starts, rl, be, bt);
      join
      n_vec++;
      if (run != 8 || bits[7:0] !== 8'b1000_0000) begin
         n_err++;
         $display("FAIL lsb_order got=%0d bits %b required=8 bits 10000000", run, bits[7:0]);
      end
      n_vec++;
      if (starts !== 64'h1 || q_lsb.size() != 0) begin
         n_err++;
         $display("FAIL lsb_start got=%h q %0d required=1 q 0", starts, q_lsb.size());
      end
   endtask

   task automatic test_detector_feed;
      logic [W-1:0] ws [4];
      logic [7:0] ref_seq;
      int st, run, rl;
      logic [63:0] bits, starts;
      logic be, bt;
      ref_seq = 8'b0010_0000;
      ws = '{8'h20, 8'h00, 8'h00, 8'h00};
      fork
         stream(1'b0, ws, 1, st);
         observe(1'b0, run, bits, starts, rl, be, bt);
      join
      n_vec++;
      if (run != 8 || bits[7:0] !== ref_seq) begin
         n_err++;
         $display("FAIL detector_seq got=%0d bits %b required=8 bits %b",
                  run, bits[7:0], ref_seq);
      end
      n_vec++;
      if (q_msb.size() != 0) begin
         n_err++;
         $display("FAIL detector_drain got=%0d required=0", q_msb.size());
      end
   endtask

   initial begin
      bm.in_valid = 1'b0;
      bm.in_data  = '0;
      bl.in_valid = 1'b0;
      bl.in_data  = '0;
      test_reset();
      test_single();
      test_back_to_back();
      repeat (3) @(posedge clk);
      test_hold_stall();
      repeat (3) @(posedge clk);
      test_reset_mid_word();
      test_lsb_first();
      test_detector_feed();
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
